boot_cmd_sequencer: RTL and testbench
=====================================

Name: boot_cmd_sequencer

Overview:
Parametrised bootstrap command sequencer, sitting between the top-level control and the bootstrap/SPI core. It raises the bootstrap init request, then issues a programmable table of SD command words on the SPI data bus, advancing on matching SPI flag codes. A final drain step holds the idle word until the completion flag arrives. Each step has a timeout with bounded retry and a sticky error report.

Parameters:
DATA_W, 48, SPI command word width
FLAG_W, 3, spi flag register width
STAT_W, 9, spi status register width
N_CMDS, 4, command table depth (≥1)
TIMEOUT_W, 16, timeout counter width
MAX_RETRY, 3, retries per step before error (0 = no retry)
STAT_INIT, 9'b110100011, status word driven during INIT
STAT_CMD, 9'b110100111, status word driven during CMD and DRAIN
IDLE_WORD, all ones, spi_data_o value outside CMD
FINAL_FLAG, 3'b110, flag code ending DRAIN

Ports:
master_clk_i  in  1  system clock
master_rst_i  in  1  reset, asynchronous, active-low
start_i  in  1  begin sequence (pulse; honoured in IDLE, DONE, ERROR)
abort_i  in  1  return to IDLE from any state
cmd_wr_en_i  in  1  table write strobe
cmd_wr_addr_i  in  clog2(N_CMDS)  table entry index
cmd_wr_data_i  in  DATA_W  command word
cmd_wr_flag_i  in  FLAG_W  flag code that completes this entry
cmd_count_i  in  clog2(N_CMDS+1)  active entries, sampled on start
timeout_i  in  TIMEOUT_W  cycles per step; 0 disables timeout
bootstrap_initdone_i  in  1  bootstrap init complete
spi_flagreg_i  in  FLAG_W  SPI progress flag
bootstrap_init_o  out  1  init request
spi_data_o  out  DATA_W  command word to SPI
spi_statusreg_o  out  STAT_W  SPI status/control word
busy_o  out  1  sequence in progress
done_o  out  1  sequence complete (level)
error_o  out  1  sticky error
err_code_o  out  2  01 init, 10 cmd, 11 drain timeout
cmd_idx_o  out  clog2(N_CMDS)  current entry
retry_cnt_o  out  clog2(MAX_RETRY+1)  retries used in current step

Behaviour:
- All outputs registered. Reset: state IDLE, bootstrap_init_o=0, spi_data_o=IDLE_WORD, spi_statusreg_o=0, busy/done/error=0, err_code=00, idx=0, retry=0. Table entries reset to data 0, flag 0.
- Table write: accepted only when not busy_o. Writes while busy are ignored. Out-of-range address is ignored.
- IDLE: outputs at reset values. On start_i, latch cmd_count_i (values above N_CMDS clamp to N_CMDS), clear done/error/err_code, and go to INIT next cycle.
- INIT: bootstrap_init_o=1, status=STAT_INIT. When bootstrap_initdone_i=1, go to CMD if count>0, else DRAIN.
- CMD: spi_data_o=table[idx].data, status=STAT_CMD. When spi_flagreg_i==table[idx].flag:
  - if idx==count-1, go to DRAIN;
  - otherwise idx+1 and stay in CMD.
  - Each advance lands the new word on the next cycle.
- DRAIN: spi_data_o=IDLE_WORD, status=STAT_CMD. When flag==FINAL_FLAG, go to DONE.
- DONE: done_o=1, busy_o=0, init=0, status=0, data=IDLE_WORD. Held until start_i or abort_i.
- busy_o=1 in INIT, CMD, DRAIN and RETRY.
- Timeout: the step counter clears on entry to every step (including each CMD advance) and increments each cycle. When counter==timeout_i-1 with no advance:
  - if retry<MAX_RETRY, go to RETRY;
  - otherwise go to ERROR.
  - An advance condition in the same cycle as the timeout wins.
- RETRY: one cycle with init=0, status=0, data=IDLE_WORD, retry+1. Then re-enter the same step with the same idx. retry clears on a successful step advance.
- ERROR: error_o=1, err_code per failing step, busy=0, other outputs as IDLE. Sticky until start_i (restarts the sequence) or abort_i/reset.
- abort_i has priority over every transition. Next cycle: IDLE, all outputs at reset values, error cleared.
- Async reset mid-sequence: immediate return to reset values; the table is also cleared.

Test Plan:
- Nominal: table[0]=48'h5800002A0001/flag 100, table[1]=48'hFE8623220000/flag 101, count=2, timeout=0. Start; initdone after 5 cycles; flags 100, 101, 110 in turn → init high during INIT with status 9'h1A3; data words in order with status 9'h1A7; IDLE_WORD during DRAIN; done_o=1; error_o=0.
- Timeout recovery: timeout=8, MAX_RETRY=3, withhold flag 100 for 10 cycles → one RETRY cycle (status 0), retry_cnt_o=1, word re-issued, sequence then completes with done_o=1.
- Retry exhaustion: flag never 101 → after 4 timeouts error_o=1, err_code_o=10, cmd_idx_o=1, busy_o=0. A following start_i restarts from INIT.
- count=0 and count=7 (N_CMDS=4): count 0 goes INIT→DRAIN directly; count 7 issues exactly 4 entries.
- Abort and write-while-busy: write entry 0 during CMD (ignored, old word stays); abort_i in CMD → IDLE next cycle with outputs at reset values.
- Async reset asserted mid-DRAIN, between clock edges → outputs at reset values before the next edge; table reads zero after release.

Source files
------------

// File: rtl/boot_cmd_sequencer.sv
// Bootstrap command sequencer: raises the bootstrap init request, walks a
// programmable table of SD command words on the SPI data bus, advancing on
// matching SPI flag codes, then drains with the idle word until the final
// flag arrives. Every step has a timeout with bounded retry and a sticky error.
module boot_cmd_sequencer #(
  parameter int unsigned          DATA_W     = 48,
  parameter int unsigned          FLAG_W     = 3,
  parameter int unsigned          STAT_W     = 9,
  parameter int unsigned          N_CMDS     = 4,
  parameter int unsigned          TIMEOUT_W  = 16,
  parameter int unsigned          MAX_RETRY  = 3,
  parameter logic [STAT_W-1:0]    STAT_INIT  = 9'b110100011,
  parameter logic [STAT_W-1:0]    STAT_CMD   = 9'b110100111,
  parameter logic [DATA_W-1:0]    IDLE_WORD  = '1,
  parameter logic [FLAG_W-1:0]    FINAL_FLAG = 3'b110,
  localparam int unsigned         IDX_W      = (N_CMDS > 1) ? $clog2(N_CMDS) : 1,
  localparam int unsigned         CNT_W      = $clog2(N_CMDS + 1),
  localparam int unsigned         RTY_W      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic                 master_clk_i,
  input  logic                 master_rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 cmd_wr_en_i,
  input  logic [IDX_W-1:0]     cmd_wr_addr_i,
  input  logic [DATA_W-1:0]    cmd_wr_data_i,
  input  logic [FLAG_W-1:0]    cmd_wr_flag_i,
  input  logic [CNT_W-1:0]     cmd_count_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  input  logic                 bootstrap_initdone_i,
  input  logic [FLAG_W-1:0]    spi_flagreg_i,
  output logic                 bootstrap_init_o,
  output logic [DATA_W-1:0]    spi_data_o,
  output logic [STAT_W-1:0]    spi_statusreg_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [1:0]           err_code_o,
  output logic [IDX_W-1:0]     cmd_idx_o,
  output logic [RTY_W-1:0]     retry_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_CMDS);
  localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_CMD,
    S_DRAIN,
    S_RETRY,
    S_DONE,
    S_ERROR
  } state_e;

  state_e                 state_q, state_d;
  state_e                 step_q, step_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [RTY_W-1:0]       retry_q, retry_d;
  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [1:0]             err_code_q, err_code_d;

  logic                   init_q, init_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [STAT_W-1:0]      stat_q, stat_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;

  logic                   advance;
  logic                   expired;
  logic                   step_active;
  logic                   last_entry;

  logic [DATA_W-1:0]      tbl_data_q [N_CMDS];
  logic [FLAG_W-1:0]      tbl_flag_q [N_CMDS];

  // Command table: writable only while no sequence is running.
  always_ff @(posedge master_clk_i or negedge master_rst_i) begin
    if (!master_rst_i) begin
      for (int unsigned i = 0; i < N_CMDS; i++) begin
        tbl_data_q[i] <= '0;
        tbl_flag_q[i] <= '0;
      end
    end else if (cmd_wr_en_i && !busy_q && (32'(cmd_wr_addr_i) < N_CMDS)) begin
      tbl_data_q[cmd_wr_addr_i] <= cmd_wr_data_i;
      tbl_flag_q[cmd_wr_addr_i] <= cmd_wr_flag_i;
    end
  end

  // Sequencer state, step bookkeeping and registered outputs.
  always_ff @(posedge master_clk_i or negedge master_rst_i) begin
    if (!master_rst_i) begin
      state_q    <= S_IDLE;
      step_q     <= S_INIT;
      idx_q      <= '0;
      retry_q    <= '0;
      cnt_q      <= '0;
      count_q    <= '0;
      err_code_q <= '0;
      init_q     <= 1'b0;
      data_q     <= IDLE_WORD;
      stat_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      cnt_q      <= cnt_d;
      count_q    <= count_d;
      err_code_q <= err_code_d;
      init_q     <= init_d;
      data_q     <= data_d;
      stat_q     <= stat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so that every
  // output is a flop yet still changes on the same edge as the state.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    cnt_d       = cnt_q + TIMEOUT_W'(1);
    count_d     = count_q;
    err_code_d  = err_code_q;
    advance     = 1'b0;
    step_active = (state_q == S_INIT) || (state_q == S_CMD) || (state_q == S_DRAIN);
    expired     = (timeout_i != '0) && (cnt_q == (timeout_i - TIMEOUT_W'(1)));
    last_entry  = ((CNT_W'(idx_q) + CNT_W'(1)) == count_q);

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d    = S_INIT;
          count_d    = (cmd_count_i > CNT_MAX) ? CNT_MAX : cmd_count_i;
          err_code_d = '0;
          idx_d      = '0;
          retry_d    = '0;
          cnt_d      = '0;
        end
      end
      S_INIT: begin
        if (bootstrap_initdone_i) begin
          advance = 1'b1;
          idx_d   = '0;
          state_d = (count_q == '0) ? S_DRAIN : S_CMD;
        end
      end
      S_CMD: begin
        if (spi_flagreg_i == tbl_flag_q[idx_q]) begin
          advance = 1'b1;
          if (last_entry) begin
            state_d = S_DRAIN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (spi_flagreg_i == FINAL_FLAG) begin
          advance = 1'b1;
          state_d = S_DONE;
        end
      end
      S_RETRY: begin
        state_d = step_q;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // A successful advance takes precedence over a timeout in the same cycle.
    if (advance) begin
      retry_d = '0;
      cnt_d   = '0;
    end else if (step_active && expired) begin
      if (retry_q < RTY_MAX) begin
        state_d = S_RETRY;
        step_d  = state_q;
        retry_d = retry_q + RTY_W'(1);
      end else begin
        state_d = S_ERROR;
        case (state_q)
          S_INIT:  err_code_d = 2'b01;
          S_CMD:   err_code_d = 2'b10;
          default: err_code_d = 2'b11;
        endcase
      end
    end

    if (abort_i) begin
      state_d    = S_IDLE;
      idx_d      = '0;
      retry_d    = '0;
      cnt_d      = '0;
      err_code_d = '0;
    end

    init_d = (state_d == S_INIT);
    data_d = IDLE_WORD;
    stat_d = '0;
    case (state_d)
      S_INIT:  stat_d = STAT_INIT;
      S_CMD: begin
        stat_d = STAT_CMD;
        data_d = tbl_data_q[idx_d];
      end
      S_DRAIN: stat_d = STAT_CMD;
      default: ;
    endcase
    busy_d  = (state_d == S_INIT) || (state_d == S_CMD) ||
              (state_d == S_DRAIN) || (state_d == S_RETRY);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERROR);
  end

  assign bootstrap_init_o = init_q;
  assign spi_data_o       = data_q;
  assign spi_statusreg_o  = stat_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign error_o          = error_q;
  assign err_code_o       = err_code_q;
  assign cmd_idx_o        = idx_q;
  assign retry_cnt_o      = retry_q;

endmodule

// File: tb/tb_boot_cmd_sequencer.sv
// Self-checking bench for boot_cmd_sequencer: scripted and randomized
// sequences checked against a step-level reference of the expected outputs.
`timescale 1ns/1ps
module tb_boot_cmd_sequencer;

  localparam int          DATA_W    = 48;
  localparam int          FLAG_W    = 3;
  localparam int          STAT_W    = 9;
  localparam int          N_CMDS    = 4;
  localparam int          TIMEOUT_W = 16;
  localparam int          MAX_RETRY = 3;
  localparam logic [47:0] IDLE_W    = 48'hFFFF_FFFF_FFFF;
  localparam logic [8:0]  ST_INIT   = 9'h1A3;
  localparam logic [8:0]  ST_CMD    = 9'h1A7;
  localparam logic [2:0]  FINAL     = 3'b110;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [47:0] wr_data = '0;
  logic [2:0]  wr_flag = '0;
  logic [2:0]  cmd_count = '0;
  logic [15:0] timeout = '0;
  logic        initdone = 1'b0;
  logic [2:0]  flag = '0;
  logic        init_o, busy_o, done_o, error_o;
  logic [47:0] data_o;
  logic [8:0]  stat_o;
  logic [1:0]  err_code_o, idx_o, retry_o;

  int n_checks = 0;
  int n_fail = 0;

  logic [47:0] ref_data [N_CMDS];
  logic [2:0]  ref_flag [N_CMDS];

  always #5 clk = ~clk;

  boot_cmd_sequencer #(
    .DATA_W(DATA_W), .FLAG_W(FLAG_W), .STAT_W(STAT_W), .N_CMDS(N_CMDS),
    .TIMEOUT_W(TIMEOUT_W), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .master_clk_i(clk), .master_rst_i(rst_n), .start_i(start), .abort_i(abort),
    .cmd_wr_en_i(wr_en), .cmd_wr_addr_i(wr_addr), .cmd_wr_data_i(wr_data),
    .cmd_wr_flag_i(wr_flag), .cmd_count_i(cmd_count), .timeout_i(timeout),
    .bootstrap_initdone_i(initdone), .spi_flagreg_i(flag),
    .bootstrap_init_o(init_o), .spi_data_o(data_o), .spi_statusreg_o(stat_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_code_o(err_code_o),
    .cmd_idx_o(idx_o), .retry_cnt_o(retry_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic init, input logic [47:0] data,
                          input logic [8:0] stat, input logic busy, input logic done,
                          input logic err);
    chk({tag, ".init"}, 64'(init_o), 64'(init));
    chk({tag, ".data"}, 64'(data_o), 64'(data));
    chk({tag, ".stat"}, 64'(stat_o), 64'(stat));
    chk({tag, ".busy"}, 64'(busy_o), 64'(busy));
    chk({tag, ".done"}, 64'(done_o), 64'(done));
    chk({tag, ".error"}, 64'(error_o), 64'(err));
  endtask

  task automatic check_idle(input string tag);
    chk_outs(tag, 1'b0, IDLE_W, 9'h0, 1'b0, 1'b0, 1'b0);
    chk({tag, ".errcode"}, 64'(err_code_o), 64'd0);
    chk({tag, ".idx"}, 64'(idx_o), 64'd0);
    chk({tag, ".retry"}, 64'(retry_o), 64'd0);
  endtask

  // kind: 0 = init wait, 1 = command entry idx, 2 = drain
  task automatic exp_step(input string tag, input int kind, input int idx, input int rty);
    case (kind)
      0:       chk_outs(tag, 1'b1, IDLE_W, ST_INIT, 1'b1, 1'b0, 1'b0);
      1:       chk_outs(tag, 1'b0, ref_data[idx], ST_CMD, 1'b1, 1'b0, 1'b0);
      default: chk_outs(tag, 1'b0, IDLE_W, ST_CMD, 1'b1, 1'b0, 1'b0);
    endcase
    chk({tag, ".idx"}, 64'(idx_o), 64'(idx));
    chk({tag, ".retry"}, 64'(retry_o), 64'(rty));
  endtask

  // Present inputs that either complete the step (adv=1) or certainly do not.
  task automatic drive(input int kind, input int idx, input bit adv);
    case (kind)
      0: begin
        initdone = adv;
        flag     = 3'($urandom);
      end
      1: begin
        initdone = 1'($urandom);
        flag     = adv ? ref_flag[idx] : (ref_flag[idx] ^ 3'($urandom_range(1, 7)));
      end
      default: begin
        initdone = 1'($urandom);
        flag     = adv ? FINAL : (FINAL ^ 3'($urandom_range(1, 7)));
      end
    endcase
  endtask

  task automatic write_entry(input int a, input logic [47:0] d, input logic [2:0] f,
                             input bit expect_taken);
    wr_en = 1'b1; wr_addr = 2'(a); wr_data = d; wr_flag = f;
    tick();
    wr_en = 1'b0;
    if (expect_taken) begin
      ref_data[a] = d;
      ref_flag[a] = f;
    end
  endtask

  // Run one full sequence. fail_step gets fail_n timeouts; a step that times
  // out more than MAX_RETRY times ends the sequence in ERROR.
  task automatic run_seq(input int cnt_in, input int t, input int init_w,
                         input int fail_step, input int fail_n);
    int n, nfail, w, kind, idx;
    n = (cnt_in > N_CMDS) ? N_CMDS : cnt_in;
    cmd_count = 3'(cnt_in);
    timeout   = 16'(t);
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 0; s <= n + 1; s++) begin
      kind  = (s == 0) ? 0 : ((s <= n) ? 1 : 2);
      idx   = (s == 0) ? 0 : ((s <= n) ? s - 1 : ((n == 0) ? 0 : n - 1));
      nfail = (s == fail_step) ? fail_n : ((t > 0) ? int'($urandom_range(0, 1)) : 0);
      for (int a = 0; a < nfail; a++) begin
        for (int c = 0; c < t; c++) begin
          exp_step($sformatf("s%0d.a%0d.c%0d", s, a, c), kind, idx, a);
          drive(kind, idx, 1'b0);
          tick();
        end
        if (a < MAX_RETRY) begin
          chk_outs($sformatf("retry.s%0d.a%0d", s, a), 1'b0, IDLE_W, 9'h0, 1'b1, 1'b0, 1'b0);
          chk("retry.idx", 64'(idx_o), 64'(idx));
          chk("retry.cnt", 64'(retry_o), 64'(a + 1));
          drive(kind, idx, 1'b1);
          tick();
        end else begin
          chk_outs($sformatf("error.s%0d", s), 1'b0, IDLE_W, 9'h0, 1'b0, 1'b0, 1'b1);
          chk("error.code", 64'(err_code_o), 64'(kind + 1));
          chk("error.idx", 64'(idx_o), 64'(idx));
          initdone = 1'b0;
          return;
        end
      end
      if (s == 0 && init_w >= 0) w = init_w;
      else if (t == 0) w = int'($urandom_range(0, 4));
      else if ($urandom_range(0, 3) == 0) w = t - 1;
      else w = int'($urandom_range(0, t - 1));
      for (int c = 0; c < w; c++) begin
        exp_step($sformatf("s%0d.w%0d", s, c), kind, idx, nfail);
        drive(kind, idx, 1'b0);
        tick();
      end
      exp_step($sformatf("s%0d.adv", s), kind, idx, nfail);
      drive(kind, idx, 1'b1);
      tick();
    end
    chk_outs("done", 1'b0, IDLE_W, 9'h0, 1'b0, 1'b1, 1'b0);
    chk("done.errcode", 64'(err_code_o), 64'd0);
    initdone = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N_CMDS; i++) begin
      ref_data[i] = '0;
      ref_flag[i] = '0;
    end

    // reset values, during and just after reset
    #22;
    check_idle("rst.hold");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_idle("rst.rel");

    // nominal two-entry sequence, no timeout, init done after 5 cycles
    write_entry(0, 48'h5800002A0001, 3'b100, 1'b1);
    write_entry(1, 48'hFE8623220000, 3'b101, 1'b1);
    run_seq(2, 0, 5, -1, 0);

    // one timeout on entry 0, then recovery
    run_seq(2, 8, -1, 1, 1);

    // retry exhaustion on entry 1, then restart from ERROR
    run_seq(2, 8, -1, 2, MAX_RETRY + 1);
    run_seq(2, 8, -1, -1, 0);

    // count 0 skips straight to drain; count 7 clamps to 4 entries
    run_seq(0, 0, -1, -1, 0);
    write_entry(2, 48'h123456789ABC, 3'b011, 1'b1);
    write_entry(3, 48'h0F0F0F0F0F0F, 3'b000, 1'b1);
    run_seq(7, 5, -1, -1, 0);

    // write while busy is ignored; abort from CMD returns to IDLE
    cmd_count = 3'd2; timeout = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    exp_step("ab.init", 0, 0, 0);
    drive(0, 0, 1'b1);
    tick();
    exp_step("ab.cmd0", 1, 0, 0);
    drive(1, 0, 1'b0);
    write_entry(0, 48'hDEADBEEFCAFE, 3'b111, 1'b0);
    exp_step("ab.wr1", 1, 0, 0);
    drive(1, 0, 1'b0);
    tick();
    exp_step("ab.wr2", 1, 0, 0);
    abort = 1'b1;
    drive(1, 0, 1'b1);
    tick();
    abort = 1'b0;
    initdone = 1'b0;
    check_idle("ab.idle");
    run_seq(2, 0, -1, -1, 0);

    // asynchronous reset mid-drain, between edges; table cleared
    cmd_count = 3'd0; timeout = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    drive(0, 0, 1'b1);
    tick();
    exp_step("ar.drain", 2, 0, 0);
    drive(2, 0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle("ar.async");
    initdone = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N_CMDS; i++) begin
      ref_data[i] = '0;
      ref_flag[i] = '0;
    end
    tick();
    check_idle("ar.rel");
    run_seq(4, 0, -1, -1, 0);

    // randomized sequences
    for (int r = 0; r < 8; r++) begin
      int nw, t, cnt, n, fs, fn;
      nw = int'($urandom_range(1, 4));
      for (int k = 0; k < nw; k++)
        write_entry(int'($urandom_range(0, 3)), {$urandom(), $urandom()} >> 16,
                    3'($urandom), 1'b1);
      t   = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(2, 9));
      cnt = int'($urandom_range(0, 7));
      n   = (cnt > N_CMDS) ? N_CMDS : cnt;
      fs  = -1;
      fn  = 0;
      if (t > 0 && $urandom_range(0, 2) == 0) begin
        fs = int'($urandom_range(0, n + 1));
        fn = MAX_RETRY + 1;
      end
      run_seq(cnt, t, -1, fs, fn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
